// File: rtl/seq_det_pkg.sv
// Shared types and reset-default configuration for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_DONE
    } state_t;

    localparam int unsigned DEF_PATTERN = 32'h5;  // 'b101
    localparam int unsigned DEF_LEN     = 3;
    localparam logic        DEF_OVERLAP = 1'b1;
    localparam int unsigned DEF_TARGET  = 0;

endpackage

// File: rtl/seq_shift_match.sv
// History shift register, fill counter and length-masked comparator.
// hit reflects the value that would be held after shifting bit_in in.
module seq_shift_match #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift,
    input  logic               clear,
    input  logic               overlap,
    input  logic               bit_in,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W:0]     fill_inc;

    always_comb begin
        hist_next = {hist[MAX_LEN-2:0], bit_in};
        mask      = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len)) begin
                mask[i] = 1'b1;
            end
        end
        fill_inc = {1'b0, fill} + 1'b1;
        hit      = shift && (fill_inc >= {1'b0, len}) && (((hist_next ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_next;
            // Non-overlapping mode: the next match must be built from fresh bits.
            if (hit && !overlap) begin
                fill <= '0;
            end else if (fill < LEN_W'(MAX_LEN)) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detection controller: config registers, run FSM,
// saturating match counter and registered status outputs.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic               cfg_err
);

    state_t             state;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;

    logic               shift;
    logic               clear;
    logic               hit;
    logic               len_ok;
    logic [CNT_W-1:0]   count_next;

    always_comb begin
        shift      = (state == S_ARMED) && bit_valid && !abort;
        clear      = start && (state != S_ARMED) && !abort;
        len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        count_next = (match_count == '1) ? match_count : match_count + 1'b1;
    end

    seq_shift_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shift_match (
        .clk     (clk),
        .rst     (rst),
        .shift   (shift),
        .clear   (clear),
        .overlap (overlap_q),
        .bit_in  (bit_in),
        .len     (len_q),
        .pattern (pattern_q),
        .hit     (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pattern_q   <= MAX_LEN'(DEF_PATTERN);
            len_q       <= LEN_W'(DEF_LEN);
            overlap_q   <= DEF_OVERLAP;
            target_q    <= CNT_W'(DEF_TARGET);
            busy        <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            match   <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_we) begin
                if ((state == S_IDLE) && len_ok) begin
                    pattern_q <= cfg_pattern;
                    len_q     <= cfg_len;
                    overlap_q <= cfg_overlap;
                    target_q  <= cfg_target;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start && (state != S_ARMED)) begin
                state       <= S_ARMED;
                busy        <= 1'b1;
                done        <= 1'b0;
                match_count <= '0;
            end else if (shift && hit) begin
                match       <= 1'b1;
                match_count <= count_next;
                if ((target_q != '0) && (count_next == target_q)) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl; expected match pulses go through a scoreboard queue.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       busy;
    logic       match;
    logic [7:0] match_count;
    logic       done;
    logic       cfg_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    seq_detect_ctrl #(
        .MAX_LEN (8),
        .LEN_W   (4),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .busy        (busy),
        .match       (match),
        .match_count (match_count),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input bit exp_match);
        bit e;
        bit_valid = 1'b1;
        bit_in    = b;
        exp_q.push_back(exp_match);
        step();
        bit_valid = 1'b0;
        e = exp_q.pop_front();
        chk("match", 32'(match), 32'(e));
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic [7:0] tgt);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_target  = tgt;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_count", 32'(match_count), 32'd0);
        rst = 1'b0;
        step();

        // 1: default 101, overlapping
        do_start();
        chk("t1_busy_armed", 32'(busy), 32'd1);
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 1); send_bit(0, 0); send_bit(1, 1);
        chk("t1_count", 32'(match_count), 32'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_done", 32'(done), 32'd0);

        // 2: non-overlapping 101
        do_abort();
        do_cfg(8'b101, 4'd3, 1'b0, 8'd0);
        do_start();
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 1); send_bit(0, 0);
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 1);
        chk("t2_count", 32'(match_count), 32'd2);

        // 3: target 2, pattern 11
        do_abort();
        do_cfg(8'b11, 4'd2, 1'b1, 8'd2);
        do_start();
        send_bit(1, 0); send_bit(1, 1); send_bit(1, 1);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        send_bit(1, 0);
        chk("t3_count", 32'(match_count), 32'd2);
        chk("t3_done_hold", 32'(done), 32'd1);

        // 4: rejected config writes
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_cfg(8'b11, 4'd0, 1'b1, 8'd1);
        chk("t4_err_len0", 32'(cfg_err), 32'd1);
        step();
        chk("t4_err_pulse", 32'(cfg_err), 32'd0);
        do_start();
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 1);
        do_cfg(8'b11, 4'd2, 1'b1, 8'd1);
        chk("t4_err_armed", 32'(cfg_err), 32'd1);
        send_bit(0, 0); send_bit(1, 1);
        chk("t4_done", 32'(done), 32'd0);

        // 5: abort on the completing bit
        do_abort();
        do_start();
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 1); send_bit(0, 0);
        abort = 1'b1;
        send_bit(1, 0);
        abort = 1'b0;
        chk("t5_count", 32'(match_count), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        send_bit(1, 0);
        chk("t5_count_idle", 32'(match_count), 32'd1);

        // 6: len 1 pattern 1, saturate the counter, then async reset mid-run
        do_cfg(8'b1, 4'd1, 1'b1, 8'd0);
        do_start();
        for (int i = 0; i < 255; i++) begin
            send_bit(1, 1);
        end
        chk("t6_count_255", 32'(match_count), 32'd255);
        send_bit(1, 1);
        chk("t6_count_sat", 32'(match_count), 32'd255);
        chk("t6_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_match", 32'(match), 32'd0);
        chk("t6_rst_count", 32'(match_count), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_err", 32'(cfg_err), 32'd0);
        step();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
